// File: rtl/cnu_row_seq.sv
// Row sequencer for the check-node cell: issues LR/LQ reads, stage
// strobes and write-back strobes, and loops over decode iterations.
module cnu_row_seq #(
   parameter int ROW_W      = 8,
   parameter int ITER_W     = 5,
   parameter int ROW_PERIOD = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ROW_W-1:0]  num_rows,
   input  logic [ITER_W-1:0] max_iter,
   input  logic              early_stop,
   output logic              busy,
   output logic              done,
   output logic              iter_0,
   output logic [ITER_W-1:0] iter_cnt,
   output logic [ROW_W-1:0]  rd_addr,
   output logic              lr_rd_en,
   output logic              lq_rd_en,
   output logic [6:0]        cnu_out,
   output logic              wr_en,
   output logic [ROW_W-1:0]  wr_addr
);

   typedef enum logic [2:0] {
      S_IDLE, S_RUN, S_DRAIN, S_ITER_END, S_FIN
   } state_t;

   localparam logic [2:0] PH_LAST = 3'(ROW_PERIOD - 1);

   state_t                 st, st_nx;
   logic [ROW_W-1:0]       nr_q;
   logic [ROW_W-1:0]       r_q;
   logic [ROW_W-1:0]       lq_addr_q;
   logic [ITER_W-1:0]      max_q;
   logic [2:0]             ph_q;
   logic                   lq_q;
   logic [6:0]             sh_q;
   logic [5:0][ROW_W-1:0]  ad_q;
   logic                   issue;
   logic                   last_row;
   logic                   iter_last;
   logic                   drained;

   assign issue     = (st == S_RUN) && (ph_q == 3'd0);
   assign last_row  = (r_q == nr_q - ROW_W'(1));
   assign iter_last = ({1'b0, iter_cnt} + (ITER_W+1)'(1)) >= {1'b0, max_q};
   assign drained   = sh_q[6] && (sh_q[5:0] == 6'd0);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) st <= S_IDLE;
      else          st <= st_nx;
   end

   // Next-state decode; an empty matrix still passes through ITER_END
   always_comb begin
      st_nx = st;
      unique case (st)
         S_IDLE:
            if (start) st_nx = (num_rows == '0) ? S_ITER_END : S_RUN;
         S_RUN:
            if (issue && last_row) st_nx = S_DRAIN;
         S_DRAIN:
            if (drained) st_nx = S_ITER_END;
         S_ITER_END:
            if (early_stop || nr_q == '0 || iter_last) st_nx = S_FIN;
            else                                      st_nx = S_RUN;
         S_FIN:
            st_nx = S_IDLE;
         default:
            st_nx = S_IDLE;
      endcase
   end

   // Row/phase/iteration counters and latched decode parameters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nr_q     <= '0;
         max_q    <= '0;
         r_q      <= '0;
         ph_q     <= '0;
         iter_cnt <= '0;
      end else begin
         unique case (st)
            S_IDLE:
               if (start) begin
                  nr_q     <= num_rows;
                  max_q    <= (max_iter == '0) ? ITER_W'(1) : max_iter;
                  iter_cnt <= '0;
                  r_q      <= '0;
                  ph_q     <= '0;
               end
            S_RUN: begin
               ph_q <= (ph_q == PH_LAST) ? 3'd0 : ph_q + 3'd1;
               if (issue && !last_row) r_q <= r_q + ROW_W'(1);
            end
            S_ITER_END:
               if (st_nx == S_RUN) begin
                  iter_cnt <= iter_cnt + ITER_W'(1);
                  r_q      <= '0;
                  ph_q     <= '0;
               end
            default: ;
         endcase
      end
   end

   // Strobe shift line, LQ follow-up read and write-back address line
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_q      <= '0;
         lq_q      <= 1'b0;
         lq_addr_q <= '0;
         ad_q      <= '0;
      end else begin
         sh_q <= {sh_q[5:0], issue};
         lq_q <= issue;
         if (issue) lq_addr_q <= r_q;
         ad_q <= {ad_q[4:0], r_q};
      end
   end

   assign busy     = (st != S_IDLE);
   assign done     = (st == S_FIN);
   assign iter_0   = busy && (iter_cnt == '0);
   assign lr_rd_en = issue;
   assign lq_rd_en = lq_q;
   assign rd_addr  = issue ? r_q : (lq_q ? lq_addr_q : '0);
   assign cnu_out  = sh_q;
   assign wr_en    = sh_q[5];
   assign wr_addr  = sh_q[5] ? ad_q[5] : '0;

endmodule

// File: tb/tb_cnu_row_seq.sv
// Directed bench for cnu_row_seq: table of decode runs plus
// cycle-exact strobe, reset and start-handling sequences.
module tb_cnu_row_seq;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic [7:0] num_rows;
   logic [4:0] max_iter;
   logic       early_stop;
   logic       busy, done, iter_0;
   logic [4:0] iter_cnt;
   logic [7:0] rd_addr;
   logic       lr_rd_en, lq_rd_en;
   logic [6:0] cnu_out;
   logic       wr_en;
   logic [7:0] wr_addr;

   int n_chk  = 0;
   int n_fail = 0;

   logic [6:0] cnu_tr [64];
   logic       wr_tr  [64];

   typedef struct {
      int nr, mi, es, poke;
      int done_k, lr, wr, it, i0lr;
   } vec_t;

   vec_t tv [8];

   cnu_row_seq #(.ROW_W(8), .ITER_W(5), .ROW_PERIOD(3)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .num_rows(num_rows), .max_iter(max_iter),
      .early_stop(early_stop), .busy(busy), .done(done),
      .iter_0(iter_0), .iter_cnt(iter_cnt), .rd_addr(rd_addr),
      .lr_rd_en(lr_rd_en), .lq_rd_en(lq_rd_en),
      .cnu_out(cnu_out), .wr_en(wr_en), .wr_addr(wr_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Start one decode and trace it until done (bounded).
   task automatic run_case(input int nr, input int mi, input int es,
                           input int poke, output int done_k,
                           output int lr_n, output int wr_n,
                           output int it_fin, output int i0lr_n,
                           output int i0cyc_n, output int bad_n);
      logic [7:0] prev_addr;
      logic       prev_lr;
      done_k = -1; lr_n = 0; wr_n = 0; it_fin = -1;
      i0lr_n = 0; i0cyc_n = 0; bad_n = 0;
      prev_addr = '0; prev_lr = 1'b0;
      for (int i = 0; i < 64; i++) begin
         cnu_tr[i] = '0; wr_tr[i] = 1'b0;
      end
      @(posedge clk); #1;
      num_rows = 8'(nr); max_iter = 5'(mi); early_stop = es[0];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (k < 64) begin
            cnu_tr[k] = cnu_out;
            wr_tr[k]  = wr_en;
         end
         if (lq_rd_en !== prev_lr) bad_n++;
         if (lq_rd_en && rd_addr !== prev_addr) bad_n++;
         prev_lr   = lr_rd_en;
         prev_addr = rd_addr;
         if (lr_rd_en) begin
            lr_n++;
            if (iter_0) i0lr_n++;
         end
         if (iter_0) i0cyc_n++;
         if (wr_en) begin
            if (wr_addr !== 8'(wr_n % nr)) bad_n++;
            wr_n++;
         end
         if (k == poke) begin
            start = 1'b1; num_rows = 8'd9; max_iter = 5'd9;
         end
         if (k == poke + 1) start = 1'b0;
         if (done) begin
            done_k = k;
            it_fin = int'(iter_cnt);
            break;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      int dk, lrn, wrn, itf, i0l, i0c, bad;
      logic [6:0] one;

      tv[0] = '{1, 1, 0, 0, 10, 1, 1, 0, 1};
      tv[1] = '{4, 1, 0, 0, 19, 4, 4, 0, 4};
      tv[2] = '{3, 3, 0, 0, 46, 9, 9, 2, 3};
      tv[3] = '{3, 3, 1, 0, 16, 3, 3, 0, 3};
      tv[4] = '{0, 5, 0, 0,  2, 0, 0, 0, 0};
      tv[5] = '{2, 0, 0, 0, 13, 2, 2, 0, 2};
      tv[6] = '{2, 2, 0, 0, 25, 4, 4, 1, 2};
      tv[7] = '{2, 1, 0, 3, 13, 2, 2, 0, 2};

      reset_n = 1'b0; start = 1'b0; num_rows = '0;
      max_iter = '0; early_stop = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs",
          64'({busy, done, iter_0, iter_cnt, rd_addr, lr_rd_en,
               lq_rd_en, cnu_out, wr_en, wr_addr}), 64'd0);
      reset_n = 1'b1;

      foreach (tv[i]) begin
         run_case(tv[i].nr, tv[i].mi, tv[i].es, tv[i].poke,
                  dk, lrn, wrn, itf, i0l, i0c, bad);
         chk($sformatf("v%0d_done_cycle", i), 64'(dk), 64'(tv[i].done_k));
         chk($sformatf("v%0d_lr_count", i), 64'(lrn), 64'(tv[i].lr));
         chk($sformatf("v%0d_wr_count", i), 64'(wrn), 64'(tv[i].wr));
         chk($sformatf("v%0d_iter_cnt", i), 64'(itf), 64'(tv[i].it));
         chk($sformatf("v%0d_iter0_rows", i), 64'(i0l), 64'(tv[i].i0lr));
         chk($sformatf("v%0d_addr_errs", i), 64'(bad), 64'd0);
      end

      // Single row: exact strobe timing, iter_0 throughout
      run_case(1, 1, 0, 0, dk, lrn, wrn, itf, i0l, i0c, bad);
      chk("t2_done", 64'(dk), 64'd10);
      chk("t2_cnu_idle", 64'(cnu_tr[1]), 64'd0);
      for (int j = 0; j < 7; j++) begin
         one = 7'd1 << j;
         chk($sformatf("t2_cnu_k%0d", j), 64'(cnu_tr[2+j]), 64'(one));
      end
      chk("t2_wr_t6", 64'(wr_tr[6]), 64'd0);
      chk("t2_wr_t7", 64'(wr_tr[7]), 64'd1);
      chk("t2_iter0_cycles", 64'(i0c), 64'd10);

      // Start coincident with done must be ignored
      num_rows = 8'd1; max_iter = 5'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("start_at_done_busy", 64'(busy), 64'd0);
      chk("iter_hold_idle", 64'(iter_cnt), 64'd0);
      @(negedge clk);
      chk("start_at_done_busy2", 64'(busy), 64'd0);

      // Pipelined rows: overlapping strobes OR together
      run_case(4, 1, 0, 0, dk, lrn, wrn, itf, i0l, i0c, bad);
      chk("t3_cnu_t8", 64'(cnu_tr[8]), 64'h49);
      chk("t3_cnu_t9", 64'(cnu_tr[9]), 64'h12);
      chk("t3_cnu_t10", 64'(cnu_tr[10]), 64'h24);
      chk("t3_wr_t10", 64'(wr_tr[10]), 64'd1);
      chk("t3_wr_t11", 64'(wr_tr[11]), 64'd0);
      chk("t3_wr_t16", 64'(wr_tr[16]), 64'd1);

      // Reset mid-RUN, then restart
      @(posedge clk); #1;
      num_rows = 8'd4; max_iter = 5'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("t1_reset_outputs",
          64'({busy, done, iter_0, iter_cnt, rd_addr, lr_rd_en,
               lq_rd_en, cnu_out, wr_en, wr_addr}), 64'd0);
      @(posedge clk);
      #3 reset_n = 1'b1;
      run_case(1, 1, 0, 0, dk, lrn, wrn, itf, i0l, i0c, bad);
      chk("t1_restart_done", 64'(dk), 64'd10);
      chk("t1_restart_wr", 64'(wrn), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
